// File: rtl/h2d_data_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : h2d_data_feeder_pkg                                    |
// | Description : Shared types and constants for the host-to-device      |
// |               write-data feeder (state encoding, frame limits).      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package h2d_data_feeder_pkg;

  // Largest payload a single Data FIS may carry, in dwords.
  localparam int unsigned DMA_FRAME_LIMIT   = 2048;
  localparam int unsigned MAX_FRAME_DEFAULT = DMA_FRAME_LIMIT;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_REQ = 2'd1,
    ST_SEND     = 2'd2
  } state_t;

  // Size of the next payload: whatever is left, capped at the frame limit.
  function automatic int unsigned frame_clip(input int unsigned remaining,
                                             input int unsigned max_frame);
    return (remaining > max_frame) ? max_frame : remaining;
  endfunction

endpackage
`default_nettype wire

// File: rtl/h2d_data_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : h2d_data_feeder_if                                     |
// | Description : Application write port, transfer control and          |
// |               transport-layer data port of the write-data feeder.    |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface h2d_data_feeder_if #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LEN_W      = 22
);
  logic [31:0]         al_data_in;
  logic                al_data_val_in;
  logic                al_data_busy_out;
  logic                xfer_start_in;
  logic [LEN_W-1:0]    xfer_len_in;
  logic                xfer_abort_in;
  logic                xfer_busy_out;
  logic                xfer_done_out;
  logic                xfer_err_out;
  logic                frame_req_in;
  logic [31:0]         tl_data_out;
  logic                tl_data_val_out;
  logic                tl_data_last_out;
  logic                tl_data_strobe_in;
  logic [DEPTH_LOG2:0] fifo_fill_out;

  // Feeder side
  modport master (
    input  al_data_in, al_data_val_in, xfer_start_in, xfer_len_in,
           xfer_abort_in, frame_req_in, tl_data_strobe_in,
    output al_data_busy_out, xfer_busy_out, xfer_done_out, xfer_err_out,
           tl_data_out, tl_data_val_out, tl_data_last_out, fifo_fill_out
  );

  // Application / transport side
  modport slave (
    output al_data_in, al_data_val_in, xfer_start_in, xfer_len_in,
           xfer_abort_in, frame_req_in, tl_data_strobe_in,
    input  al_data_busy_out, xfer_busy_out, xfer_done_out, xfer_err_out,
           tl_data_out, tl_data_val_out, tl_data_last_out, fifo_fill_out
  );
endinterface
`default_nettype wire

// File: rtl/ram_1kx32_1kx32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ram_1kx32_1kx32                                        |
// | Description : Simple dual-port RAM, one write port and one          |
// |               registered read port.                                  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ram_1kx32_1kx32 #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port and registered read port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end
endmodule
`default_nettype wire

// File: rtl/sata_dword_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sata_dword_fifo                                        |
// | Description : First-word-fall-through dword FIFO around a           |
// |               synchronous RAM: RAM read register feeds a head       |
// |               register, so a write reaches the head two edges later.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module sata_dword_fifo #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  logic [31:0]         push_data,
  input  logic                pop,
  output logic [31:0]         head_data,
  output logic                head_valid,
  output logic                full,
  output logic [DEPTH_LOG2:0] fill
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH = CW'(2 ** DEPTH_LOG2);

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   ram_cnt;   // entries still inside the RAM
  logic [DEPTH_LOG2:0]   fill_q;    // all entries, RAM + read reg + head
  logic                  rd_valid;
  logic [31:0]           rd_data;
  logic                  do_push, do_pop, head_load, rd_issue;

  assign full       = (fill_q == DEPTH);
  assign fill       = fill_q;
  assign do_push    = push & ~full;
  assign do_pop     = pop & head_valid;
  // The head refills from the RAM read register whenever it is free or leaving.
  assign head_load  = rd_valid & (~head_valid | do_pop);
  // Fetch from RAM whenever the read register is free or being drained.
  assign rd_issue   = (ram_cnt != '0) & (~rd_valid | head_load);

  ram_1kx32_1kx32 #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (32)
  ) u_ram (
    .clk     (clk),
    .wr_en   (do_push & ~flush),
    .wr_addr (wr_ptr),
    .wr_data (push_data),
    .rd_en   (rd_issue & ~flush),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  // Pointers, occupancy and the two output pipeline stages; flush empties all.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      fill_q     <= '0;
      rd_valid   <= 1'b0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ram_cnt    <= '0;
      fill_q     <= '0;
      rd_valid   <= 1'b0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (do_push)  wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_issue) rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      ram_cnt <= ram_cnt + CW'(do_push) - CW'(rd_issue);
      fill_q  <= fill_q + CW'(do_push) - CW'(do_pop);
      if (rd_issue)       rd_valid <= 1'b1;
      else if (head_load) rd_valid <= 1'b0;
      if (head_load)   head_valid <= 1'b1;
      else if (do_pop) head_valid <= 1'b0;
      if (head_load) head_data <= rd_data;
    end
  end
endmodule
`default_nettype wire

// File: rtl/h2d_data_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : h2d_data_feeder                                        |
// | Description : Host-to-device write-data stage. Buffers application  |
// |               dwords and releases them as Data FIS payloads of at   |
// |               most MAX_FRAME dwords, one per transport frame request.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module h2d_data_feeder
  import h2d_data_feeder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 10,
  parameter int unsigned MAX_FRAME  = MAX_FRAME_DEFAULT,
  parameter int          LEN_W      = 22
) (
  input  logic              clk,
  input  logic              rst,
  h2d_data_feeder_if.master bus
);
  localparam int FCNT_W = $clog2(MAX_FRAME) + 1;

  state_t              state, state_nxt;
  logic [LEN_W-1:0]    remaining, remaining_nxt;
  logic [FCNT_W-1:0]   frame_cnt, frame_cnt_nxt;
  logic                done, done_nxt;
  logic                err, err_nxt;
  logic                fifo_full, head_valid;
  logic [31:0]         head_data;
  logic [DEPTH_LOG2:0] fill;
  logic                in_send, push, overflow, pop;

  assign in_send  = (state == ST_SEND);
  assign push     = bus.al_data_val_in & ~fifo_full;
  assign overflow = bus.al_data_val_in & fifo_full;
  assign pop      = in_send & head_valid & bus.tl_data_strobe_in;

  sata_dword_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .flush      (bus.xfer_abort_in),
    .push       (push),
    .push_data  (bus.al_data_in),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (head_valid),
    .full       (fifo_full),
    .fill       (fill)
  );

  assign bus.al_data_busy_out = fifo_full;
  assign bus.xfer_busy_out    = (state != ST_IDLE);
  assign bus.xfer_done_out    = done;
  assign bus.xfer_err_out     = err;
  assign bus.tl_data_out      = head_data;
  assign bus.tl_data_val_out  = in_send & head_valid;
  assign bus.tl_data_last_out = in_send & head_valid & (frame_cnt == FCNT_W'(1));
  assign bus.fifo_fill_out    = fill;

  // State and transfer counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      remaining <= '0;
      frame_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      remaining <= remaining_nxt;
      frame_cnt <= frame_cnt_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
    end
  end

  // Next state: abort wins, otherwise start / frame request / beat accounting
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    frame_cnt_nxt = frame_cnt;
    done_nxt      = 1'b0;
    err_nxt       = err | overflow;
    if (bus.xfer_abort_in) begin
      state_nxt     = ST_IDLE;
      remaining_nxt = '0;
      frame_cnt_nxt = '0;
      err_nxt       = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.xfer_start_in) begin
            err_nxt = overflow;
            if (bus.xfer_len_in == '0) begin
              done_nxt = 1'b1;
            end else begin
              remaining_nxt = bus.xfer_len_in;
              state_nxt     = ST_WAIT_REQ;
            end
          end
        end
        ST_WAIT_REQ: begin
          if (bus.frame_req_in) begin
            frame_cnt_nxt = FCNT_W'(frame_clip(32'(remaining), MAX_FRAME));
            state_nxt     = ST_SEND;
          end
        end
        ST_SEND: begin
          if (pop) begin
            frame_cnt_nxt = frame_cnt - FCNT_W'(1);
            remaining_nxt = remaining - LEN_W'(1);
            if (frame_cnt == FCNT_W'(1)) begin
              if (remaining == LEN_W'(1)) begin
                done_nxt  = 1'b1;
                state_nxt = ST_IDLE;
              end else begin
                state_nxt = ST_WAIT_REQ;
              end
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_h2d_data_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_h2d_data_feeder                                     |
// | Description : Two feeders (MAX_FRAME 2048 and 4) driven in lockstep, |
// |               checked every cycle against a queue-level model plus   |
// |               hand-computed expectations.                            |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_h2d_data_feeder;
  localparam int DEPTH_LOG2 = 10;
  localparam int DEPTH      = 1024;
  localparam int LEN_W      = 22;
  localparam int NCH        = 2;
  localparam int M_IDLE = 0, M_WAIT = 1, M_SEND = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]      al_data = '0;
  logic             al_val = 1'b0, xstart = 1'b0, xabort = 1'b0, freq = 1'b0, strobe = 1'b0;
  logic [LEN_W-1:0] xlen = '0;

  h2d_data_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2), .LEN_W(LEN_W)) bus0 ();
  h2d_data_feeder_if #(.DEPTH_LOG2(DEPTH_LOG2), .LEN_W(LEN_W)) bus1 ();

  assign bus0.al_data_in = al_data;      assign bus1.al_data_in = al_data;
  assign bus0.al_data_val_in = al_val;   assign bus1.al_data_val_in = al_val;
  assign bus0.xfer_start_in = xstart;    assign bus1.xfer_start_in = xstart;
  assign bus0.xfer_len_in = xlen;        assign bus1.xfer_len_in = xlen;
  assign bus0.xfer_abort_in = xabort;    assign bus1.xfer_abort_in = xabort;
  assign bus0.frame_req_in = freq;       assign bus1.frame_req_in = freq;
  assign bus0.tl_data_strobe_in = strobe; assign bus1.tl_data_strobe_in = strobe;

  h2d_data_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .MAX_FRAME(2048), .LEN_W(LEN_W)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.master));
  h2d_data_feeder #(.DEPTH_LOG2(DEPTH_LOG2), .MAX_FRAME(4), .LEN_W(LEN_W)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.master));

  // ---------------- behavioural model ----------------
  int          mf [NCH] = '{2048, 4};
  logic [31:0] m_data  [NCH][DEPTH];
  longint      m_stamp [NCH][DEPTH];
  int          m_hd [NCH], m_tl [NCH], m_cnt [NCH];
  int          m_st [NCH], m_rem [NCH], m_fc [NCH];
  bit          m_done [NCH], m_err [NCH];
  longint      cyc = 0;

  int n_cmp = 0, n_fail = 0;
  int beats [NCH], lasts [NCH], dones [NCH];
  logic [31:0] log_data [NCH][64];
  bit          log_last [NCH][64];

  // A dword is at the head once it is oldest and two edges have passed since its write.
  function automatic bit head_vis(input int ch);
    return (m_cnt[ch] > 0) && (cyc >= m_stamp[ch][m_hd[ch]] + 2);
  endfunction

  task automatic model_clear(input int ch);
    m_hd[ch] = 0; m_tl[ch] = 0; m_cnt[ch] = 0; m_st[ch] = M_IDLE;
    m_rem[ch] = 0; m_fc[ch] = 0; m_done[ch] = 0; m_err[ch] = 0;
  endtask

  task automatic model_step(input int ch);
    bit vis, full, push, ovf, pop, nd, ne;
    vis = head_vis(ch);
    if (xabort) begin
      model_clear(ch);
      m_err[ch] = 1;
      return;
    end
    full = (m_cnt[ch] == DEPTH);
    push = al_val && !full;
    ovf  = al_val && full;
    pop  = (m_st[ch] == M_SEND) && vis && strobe;
    nd = 0;
    ne = m_err[ch] || ovf;
    case (m_st[ch])
      M_IDLE: if (xstart) begin
        ne = ovf;
        if (xlen == 0) nd = 1;
        else begin m_rem[ch] = int'(xlen); m_st[ch] = M_WAIT; end
      end
      M_WAIT: if (freq) begin
        m_fc[ch] = (m_rem[ch] < mf[ch]) ? m_rem[ch] : mf[ch];
        m_st[ch] = M_SEND;
      end
      default: if (pop) begin
        if (m_fc[ch] == 1) begin
          if (m_rem[ch] == 1) begin nd = 1; m_st[ch] = M_IDLE; end
          else m_st[ch] = M_WAIT;
        end
        m_fc[ch] = m_fc[ch] - 1;
        m_rem[ch] = m_rem[ch] - 1;
      end
    endcase
    if (pop) begin m_hd[ch] = (m_hd[ch] + 1) % DEPTH; m_cnt[ch] = m_cnt[ch] - 1; end
    if (push) begin
      m_data[ch][m_tl[ch]]  = al_data;
      m_stamp[ch][m_tl[ch]] = cyc + 1;
      m_tl[ch] = (m_tl[ch] + 1) % DEPTH;
      m_cnt[ch] = m_cnt[ch] + 1;
    end
    m_done[ch] = nd;
    m_err[ch]  = ne;
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      for (int ch = 0; ch < NCH; ch++) model_clear(ch);
    end else begin
      for (int ch = 0; ch < NCH; ch++) model_step(ch);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string name, input int ch, input longint act, input longint expv);
    n_cmp = n_cmp + 1;
    if (act != expv) begin
      n_fail = n_fail + 1;
      $display("FAIL %s ch%0d t=%0t: got %0h, expected %0h", name, ch, $time, act, expv);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  logic        a_val, a_last, a_busy, a_xbusy, a_done, a_err;
  logic [31:0] a_data;
  logic [10:0] a_fill;
  bit          e_val;

  initial forever begin
    @(negedge clk);
    for (int ch = 0; ch < NCH; ch++) begin
      if (ch == 0) begin
        a_val = bus0.tl_data_val_out; a_last = bus0.tl_data_last_out; a_data = bus0.tl_data_out;
        a_busy = bus0.al_data_busy_out; a_xbusy = bus0.xfer_busy_out; a_done = bus0.xfer_done_out;
        a_err = bus0.xfer_err_out; a_fill = bus0.fifo_fill_out;
      end else begin
        a_val = bus1.tl_data_val_out; a_last = bus1.tl_data_last_out; a_data = bus1.tl_data_out;
        a_busy = bus1.al_data_busy_out; a_xbusy = bus1.xfer_busy_out; a_done = bus1.xfer_done_out;
        a_err = bus1.xfer_err_out; a_fill = bus1.fifo_fill_out;
      end
      e_val = (m_st[ch] == M_SEND) && head_vis(ch);
      check("val", ch, a_val, e_val);
      check("last", ch, a_last, e_val && (m_fc[ch] == 1));
      if (e_val) check("data", ch, a_data, m_data[ch][m_hd[ch]]);
      check("al_busy", ch, a_busy, m_cnt[ch] == DEPTH);
      check("xfer_busy", ch, a_xbusy, m_st[ch] != M_IDLE);
      check("done", ch, a_done, m_done[ch]);
      check("err", ch, a_err, m_err[ch]);
      check("fill", ch, a_fill, m_cnt[ch]);
      if (a_val && strobe && !xabort) begin
        if (beats[ch] < 64) begin
          log_data[ch][beats[ch]] = a_data;
          log_last[ch][beats[ch]] = a_last;
        end
        beats[ch] = beats[ch] + 1;
        lasts[ch] = lasts[ch] + int'(a_last);
      end
      dones[ch] = dones[ch] + int'(a_done);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    al_data = d; al_val = 1'b1; tick(); al_val = 1'b0;
  endtask

  task automatic start(input int len);
    xlen = LEN_W'(len); xstart = 1'b1; tick(); xstart = 1'b0;
  endtask

  task automatic frame_req();
    freq = 1'b1; tick(); freq = 1'b0;
  endtask

  task automatic clear_logs();
    for (int ch = 0; ch < NCH; ch++) begin beats[ch] = 0; lasts[ch] = 0; dones[ch] = 0; end
  endtask

  initial begin
    repeat (3) tick();
    check("rst_val", 0, bus0.tl_data_val_out, 0);
    check("rst_data", 0, bus0.tl_data_out, 0);
    check("rst_fill", 1, bus1.fifo_fill_out, 0);
    rst = 1'b1;
    tick();

    // Preloaded 5-dword transfer, strobe held
    clear_logs();
    for (int i = 1; i <= 5; i++) push_word(32'(i));
    start(5);
    tick(); tick();
    strobe = 1'b1;
    frame_req();
    repeat (8) tick();
    frame_req();
    repeat (4) tick();
    strobe = 1'b0;
    tick();
    check("s1_beats", 0, beats[0], 5);
    check("s1_lasts", 0, lasts[0], 1);
    check("s1_last_on_5", 0, log_last[0][4], 1);
    check("s1_done", 0, dones[0], 1);
    for (int i = 0; i < 5; i++) check("s1_beat_data", 0, log_data[0][i], i + 1);
    check("s1_beats", 1, beats[1], 5);
    check("s1_lasts", 1, lasts[1], 2);
    check("s1_fill", 0, bus0.fifo_fill_out, 0);

    // 10 dwords sliced into 4/4/2 on the small-frame feeder
    clear_logs();
    for (int i = 0; i < 10; i++) push_word(32'h10 + 32'(i));
    start(10);
    tick(); tick();
    strobe = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame_req();
      repeat (7) tick();
    end
    strobe = 1'b0;
    tick();
    check("s2_beats", 1, beats[1], 10);
    check("s2_lasts", 1, lasts[1], 3);
    check("s2_last4", 1, log_last[1][3], 1);
    check("s2_last8", 1, log_last[1][7], 1);
    check("s2_last10", 1, log_last[1][9], 1);
    check("s2_data10", 1, log_data[1][9], 32'h19);
    check("s2_done", 1, dones[1], 1);
    check("s2_lasts", 0, lasts[0], 1);

    // Empty FIFO, data trickles in every third cycle
    clear_logs();
    start(3);
    tick(); tick();
    frame_req();
    strobe = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push_word(32'h30 + 32'(k));
      tick(); tick();
    end
    repeat (5) tick();
    strobe = 1'b0;
    tick();
    check("s3_beats", 0, beats[0], 3);
    check("s3_done", 0, dones[0], 1);
    check("s3_err", 0, bus0.xfer_err_out, 0);

    // Abort after two of eight beats
    clear_logs();
    for (int i = 0; i < 8; i++) push_word(32'h40 + 32'(i));
    start(8);
    tick(); tick();
    strobe = 1'b1;
    frame_req();
    tick(); tick();
    xabort = 1'b1; tick(); xabort = 1'b0;
    strobe = 1'b0;
    check("s4_beats", 0, beats[0], 2);
    check("s4_fill", 0, bus0.fifo_fill_out, 0);
    check("s4_err", 0, bus0.xfer_err_out, 1);
    check("s4_busy", 0, bus0.xfer_busy_out, 0);
    check("s4_val", 0, bus0.tl_data_val_out, 0);
    tick(); tick();
    check("s4_no_done", 0, dones[0], 0);

    // Zero-length transfer
    start(0);
    check("s5_done", 0, bus0.xfer_done_out, 1);
    check("s5_err_cleared", 0, bus0.xfer_err_out, 0);
    tick();
    check("s5_done_gone", 0, bus0.xfer_done_out, 0);
    check("s5_idle", 0, bus0.xfer_busy_out, 0);

    // Fill to capacity, then overflow
    for (int i = 0; i < DEPTH; i++) push_word(32'h1000 + 32'(i));
    tick();
    check("s6_full", 0, bus0.al_data_busy_out, 1);
    check("s6_fill", 0, bus0.fifo_fill_out, 1024);
    check("s6_err_pre", 0, bus0.xfer_err_out, 0);
    push_word(32'hDEAD);
    tick();
    check("s6_err", 0, bus0.xfer_err_out, 1);
    check("s6_fill_held", 1, bus1.fifo_fill_out, 1024);
    xabort = 1'b1; tick(); xabort = 1'b0;
    tick();
    check("s6_flushed", 0, bus0.fifo_fill_out, 0);

    // Reset in the middle of a frame
    for (int i = 0; i < 4; i++) push_word(32'h50 + 32'(i));
    start(4);
    tick(); tick();
    strobe = 1'b1;
    frame_req();
    tick();
    #2 rst = 1'b0;
    #1;
    check("s7_val", 0, bus0.tl_data_val_out, 0);
    check("s7_last", 0, bus0.tl_data_last_out, 0);
    check("s7_data", 0, bus0.tl_data_out, 0);
    check("s7_busy", 0, bus0.xfer_busy_out, 0);
    check("s7_fill", 0, bus0.fifo_fill_out, 0);
    check("s7_err", 1, bus1.xfer_err_out, 0);
    strobe = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
